// File: rtl/noise_seq_pkg.sv
// noise_seq_pkg: shared state encoding and sample width for the noise sequencer
//   state_e  : IDLE, WARMUP, COLLECT, HOLD, FAIL
//   NIBBLE_W : width of one noise_gen sample
package noise_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT,
        ST_HOLD,
        ST_FAIL
    } state_e;

endpackage

// File: rtl/noise_seq_health.sv
// noise_seq_health: repetition-count health test on captured noise samples
//   clk, rst : clock, synchronous active-high reset
//   capture  : a sample is being captured this cycle
//   sample   : the sample value
//   restart  : forget the previous sample (next capture starts a new run)
//   fail     : pulses on the capture that makes the run reach REP_LIMIT
module noise_seq_health
    import noise_seq_pkg::*;
#(
    parameter int REP_LIMIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture,
    input  logic [NIBBLE_W-1:0] sample,
    input  logic                restart,
    output logic                fail
);

    localparam int RCW = $clog2(REP_LIMIT + 1);

    logic [RCW-1:0]      rep_cnt_q, rep_cnt_d, rep_nxt;
    logic [NIBBLE_W-1:0] prev_q, prev_d;

    // A zero count means no previous sample exists, so the next capture starts a run of 1.
    always_comb begin
        rep_nxt   = (rep_cnt_q != '0 && sample == prev_q) ? RCW'(rep_cnt_q + 1'b1) : RCW'(1);
        rep_cnt_d = restart ? '0 : capture ? rep_nxt : rep_cnt_q;
        prev_d    = capture ? sample : prev_q;
        fail      = capture && rep_nxt == RCW'(REP_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            prev_q    <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            prev_q    <= prev_d;
        end
    end

endmodule

// File: rtl/noise_seq_ctrl.sv
// noise_seq_ctrl: enables noise_gen, discards warm-up, packs 4-bit samples into words
//   clk, rst    : clock, synchronous active-high reset
//   start/stop  : session start / end pulses
//   noise_enb   : enable to noise_gen;  noise_in : noise_gen sample
//   data_out, data_valid, data_ready : packed word and its valid/ready handshake
//   busy        : not idle;  health_fail : sticky repetition-test failure
// Build option NOISE_SEQ_HEALTH_EN adds the repetition-count test and the FAIL state.
module noise_seq_ctrl
    import noise_seq_pkg::*;
#(
    parameter int WARMUP_CYCLES = 64,
    parameter int WORD_W        = 32,
    parameter int REP_LIMIT     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    output logic                noise_enb,
    input  logic [NIBBLE_W-1:0] noise_in,
    output logic [WORD_W-1:0]   data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                busy,
    output logic                health_fail
);

    localparam int NIB = WORD_W / NIBBLE_W;
    localparam int WCW = $clog2(WARMUP_CYCLES + 1);
    localparam int NCW = $clog2(NIB);
    localparam int SW  = WORD_W - NIBBLE_W;

    if (WARMUP_CYCLES < 1 || WORD_W % NIBBLE_W != 0 || WORD_W < 8 || REP_LIMIT < 2) begin : g_bad_params
        $error("noise_seq_ctrl: illegal parameter set");
    end

    state_e            state_q, state_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [NCW-1:0]    ncnt_q, ncnt_d;
    logic [SW-1:0]     shreg_q, shreg_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              stop_pend_q, stop_pend_d;
    logic              noise_enb_q, data_valid_q, busy_q, health_fail_q;
    logic              fail;

`ifdef NOISE_SEQ_HEALTH_EN
    logic capture, restart;
    assign capture = state_q == ST_COLLECT && !stop;
    assign restart = state_q == ST_WARMUP && state_d == ST_COLLECT;
    noise_seq_health #(.REP_LIMIT(REP_LIMIT)) u_health (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .sample  (noise_in),
        .restart (restart),
        .fail    (fail)
    );
`else
    assign fail = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ncnt_d      = ncnt_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        stop_pend_d = stop_pend_q;
        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d = ST_WARMUP;
                    wcnt_d  = '0;
                end
            end
            ST_WARMUP: begin
                // Counting 0..WARMUP_CYCLES gives the one-cycle start latency plus the full warm-up.
                if (stop) state_d = ST_IDLE;
                else if (wcnt_q == WCW'(WARMUP_CYCLES)) begin
                    state_d = ST_COLLECT;
                    ncnt_d  = '0;
                end else wcnt_d = wcnt_q + 1'b1;
            end
            ST_COLLECT: begin
                shreg_d = SW'({shreg_q, noise_in});
                if (fail) state_d = ST_FAIL;
                else if (stop) state_d = ST_IDLE;
                else if (ncnt_q == NCW'(NIB - 1)) begin
                    state_d     = ST_HOLD;
                    data_d      = {shreg_q, noise_in};
                    stop_pend_d = 1'b0;
                end else ncnt_d = ncnt_q + 1'b1;
            end
            ST_HOLD: begin
                // A stop never withdraws the held word; it only decides where acceptance leads.
                if (data_valid_q && data_ready) begin
                    state_d = (stop_pend_q || stop) ? ST_IDLE : ST_COLLECT;
                    ncnt_d  = '0;
                end else if (stop) stop_pend_d = 1'b1;
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
            ncnt_q        <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            stop_pend_q   <= 1'b0;
            noise_enb_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            ncnt_q        <= ncnt_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            stop_pend_q   <= stop_pend_d;
            noise_enb_q   <= state_d == ST_WARMUP || state_d == ST_COLLECT || state_d == ST_HOLD;
            data_valid_q  <= state_d == ST_HOLD;
            busy_q        <= state_d != ST_IDLE;
            health_fail_q <= state_d == ST_FAIL;
        end
    end

    assign noise_enb   = noise_enb_q;
    assign data_out    = data_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_noise_seq_ctrl.sv
// tb_noise_seq_ctrl: directed self-checking bench for noise_seq_ctrl (WARMUP=4, WORD_W=8, REP_LIMIT=4)
module tb_noise_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, data_ready;
    logic [3:0] noise_in;
    logic       noise_enb, data_valid, busy, health_fail;
    logic [7:0] data_out;
    int         errors = 0;
    int         checks = 0;

    noise_seq_ctrl #(.WARMUP_CYCLES(4), .WORD_W(8), .REP_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .noise_enb   (noise_enb),
        .noise_in    (noise_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one sampled edge; returns at the negedge after that edge.
    task automatic go();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_enb"}, noise_enb, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, data_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; data_ready = 1'b0; noise_in = 4'h0;
        cyc(2);
        idle_outs("rst");
        check("rst_data", data_out, 0);
        check("rst_hf", health_fail, 0);
        rst = 1'b0;
        cyc(1);

        // first word: valid 7 cycles after start, first capture in the MSBs
        go();
        check("t1_enb", noise_enb, 1);
        check("t1_busy", busy, 1);
        check("t1_valid0", data_valid, 0);
        cyc(5);
        check("t1_warm_valid", data_valid, 0);
        noise_in = 4'hA;
        cyc(1);
        check("t1_cap1_valid", data_valid, 0);
        noise_in = 4'h5;
        cyc(1);
        check("t1_valid", data_valid, 1);
        check("t1_data", data_out, 8'hA5);

        // backpressure: word, valid and enable stay put while noise keeps changing
        for (int i = 0; i < 10; i++) begin
            noise_in = 4'(i);
            cyc(1);
            check("t2_hold_data", data_out, 8'hA5);
            check("t2_hold_valid", data_valid, 1);
            check("t2_hold_enb", noise_enb, 1);
        end
        noise_in = 4'hC;
        data_ready = 1'b1;
        cyc(1);
        check("t2_drop", data_valid, 0);
        noise_in = 4'hD;
        data_ready = 1'b0;
        cyc(1);
        check("t2_gap", data_valid, 0);
        noise_in = 4'hE;
        cyc(1);
        check("t2_next_valid", data_valid, 1);
        check("t2_next_data", data_out, 8'hDE);

        // stop in HOLD keeps the word until it is taken, then idles
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("t4_held_valid", data_valid, 1);
        check("t4_held_data", data_out, 8'hDE);
        cyc(2);
        check("t4_still_valid", data_valid, 1);
        check("t4_busy", busy, 1);
        data_ready = 1'b1;
        cyc(1);
        data_ready = 1'b0;
        idle_outs("t4_idle");

        // start and stop together leave it idle
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        idle_outs("t4_ss");

        // stop after one captured nibble: idle next cycle, no word ever
        go();
        cyc(5);
        noise_in = 4'h1;
        cyc(1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        idle_outs("t3");
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("t3_no_valid", data_valid, 0);
        end

        // constant noise: repetition test
        data_ready = 1'b1;
        noise_in = 4'h7;
        go();
        cyc(7);
        check("t5_valid", data_valid, 1);
        check("t5_data", data_out, 8'h77);
        check("t5_hf0", health_fail, 0);
`ifdef NOISE_SEQ_HEALTH_EN
        cyc(3);
        check("t5_fail_hf", health_fail, 1);
        check("t5_fail_enb", noise_enb, 0);
        check("t5_fail_valid", data_valid, 0);
        check("t5_fail_busy", busy, 1);
        start = 1'b1; stop = 1'b1;
        cyc(2);
        start = 1'b0; stop = 1'b0;
        check("t5_sticky", health_fail, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("t5_rst_hf", health_fail, 0);
        idle_outs("t5_rst");
`else
        cyc(1);
        check("t5_acc", data_valid, 0);
        cyc(2);
        check("t5_valid2", data_valid, 1);
        check("t5_data2", data_out, 8'h77);
        check("t5_hf", health_fail, 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        idle_outs("t5_end");
`endif
        data_ready = 1'b0;

        // reset mid-COLLECT, then a full warm-up again
        go();
        cyc(6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        idle_outs("t6_rc");
        check("t6_rc_data", data_out, 0);
        go();
        cyc(5);
        noise_in = 4'h9;
        cyc(1);
        check("t6_early", data_valid, 0);
        noise_in = 4'h2;
        cyc(1);
        check("t6_valid", data_valid, 1);
        check("t6_data", data_out, 8'h92);

        // reset mid-HOLD drops the held word
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        idle_outs("t6_rh");
        check("t6_rh_data", data_out, 0);
        go();
        cyc(5);
        noise_in = 4'h4;
        cyc(1);
        check("t6_early2", data_valid, 0);
        noise_in = 4'hB;
        cyc(1);
        check("t6_valid2", data_valid, 1);
        check("t6_data2", data_out, 8'h4B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
